// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state encoding and types for the multiply/divide unit.
package mdu_pkg;

    typedef logic [2:0] mdu_op_t;

    localparam mdu_op_t MDU_NOP   = 3'b000;
    localparam mdu_op_t MDU_MULT  = 3'b001;
    localparam mdu_op_t MDU_MULTU = 3'b010;
    localparam mdu_op_t MDU_DIV   = 3'b011;
    localparam mdu_op_t MDU_DIVU  = 3'b100;
    localparam mdu_op_t MDU_MTHI  = 3'b101;
    localparam mdu_op_t MDU_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/mdu_sign_adjust.sv
// Conditional two's-complement negate; purely combinational, zero latency.
module mdu_sign_adjust #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/mdu.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; WIDTH+2 cycles per op.
// New requests are only sampled in IDLE; start while busy is dropped, flush aborts.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  mdu_op_t          op,
    input  logic [WIDTH-1:0] lvalue,
    input  logic [WIDTH-1:0] rvalue,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_t         state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div, neg_q, neg_r;

    logic accept, op_signed, op_mul, op_div, div_zero, l_neg, r_neg;
    assign accept    = (state == ST_IDLE) && start && !flush;
    assign op_mul    = (op == MDU_MULT) || (op == MDU_MULTU);
    assign op_div    = (op == MDU_DIV)  || (op == MDU_DIVU);
    assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign div_zero  = op_div && (rvalue == '0);
    // Divide by zero keeps the raw dividend so the remainder comes back as lvalue.
    assign l_neg     = op_signed && lvalue[WIDTH-1] && !div_zero;
    assign r_neg     = op_signed && rvalue[WIDTH-1];

    logic [WIDTH-1:0] abs_l, abs_r;
    mdu_sign_adjust #(.W(WIDTH)) u_abs_l (.value(lvalue), .negate(l_neg), .result(abs_l));
    mdu_sign_adjust #(.W(WIDTH)) u_abs_r (.value(rvalue), .negate(r_neg), .result(abs_r));

    // Shift-add step: add multiplicand when the current multiplier bit is set.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

    // Restoring step on a WIDTH+1 bit trial remainder.
    logic [2*WIDTH:0]   div_sh;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_nxt;
    assign div_sh  = {acc, 1'b0};
    assign rem_sh  = div_sh[2*WIDTH:WIDTH];
    assign div_ge  = rem_sh >= {1'b0, opnd};
    assign rem_sub = rem_sh[WIDTH-1:0] - opnd;
    assign div_nxt = div_ge ? {rem_sub, div_sh[WIDTH-1:1], 1'b1} : div_sh[2*WIDTH-1:0];

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    mdu_sign_adjust #(.W(2*WIDTH)) u_fix_prod (.value(acc), .negate(neg_q), .result(prod_fix));
    mdu_sign_adjust #(.W(WIDTH)) u_fix_quo (.value(acc[WIDTH-1:0]), .negate(neg_q), .result(quo_fix));
    mdu_sign_adjust #(.W(WIDTH)) u_fix_rem (.value(acc[2*WIDTH-1:WIDTH]), .negate(neg_r), .result(rem_fix));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && op_mul)      state_nxt = ST_MUL;
                else if (accept && op_div) state_nxt = ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                if (flush)         state_nxt = ST_IDLE;
                else if (cnt == '0) state_nxt = ST_FIX;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (op == MDU_MTHI) begin
                            hi   <= lvalue;
                            done <= 1'b1;
                        end else if (op == MDU_MTLO) begin
                            lo   <= lvalue;
                            done <= 1'b1;
                        end else if (op_mul || op_div) begin
                            acc    <= op_mul ? {{WIDTH{1'b0}}, abs_r} : {{WIDTH{1'b0}}, abs_l};
                            opnd   <= op_mul ? abs_l : abs_r;
                            cnt    <= CW'(WIDTH - 1);
                            is_div <= op_div;
                            neg_q  <= l_neg ^ r_neg;
                            neg_r  <= op_div && l_neg;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (!flush) begin
                        acc <= (state == ST_MUL) ? mul_nxt : div_nxt;
                        cnt <= (cnt == '0) ? cnt : cnt - CW'(1);
                    end
                end
                default: begin
                    if (!flush) begin
                        hi   <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                        lo   <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
                        done <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu at WIDTH=32: arithmetic results, latency, flush, ignore, reset, moves.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    mdu_op_t     op = MDU_NOP;
    logic [31:0] lvalue = '0;
    logic [31:0] rvalue = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;
    int bc, dc;

    mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .lvalue(lvalue), .rvalue(rvalue), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, then watch from the cycle after the accept edge until done (bounded).
    task automatic run(input mdu_op_t o, input logic [31:0] l, input logic [31:0] r,
                       output int busy_cyc, output int done_cnt);
        @(negedge clk);
        start = 1'b1; op = o; lvalue = l; rvalue = r;
        @(negedge clk);
        start = 1'b0;
        busy_cyc = 0;
        done_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            if (done) break;
            @(negedge clk);
        end
    endtask

    initial begin
        #12;
        chk("reset_hi", 64'(hi), 64'h0);
        chk("reset_lo", 64'(lo), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dc);
        chk("multu_max_hi", 64'(hi), 64'hFFFFFFFE);
        chk("multu_max_lo", 64'(lo), 64'h00000001);
        chk("multu_busy_cycles", 64'(bc), 64'd33);
        chk("multu_done_count", 64'(dc), 64'd1);
        @(negedge clk);
        chk("multu_done_single", 64'(done), 64'h0);

        run(MDU_MULT, 32'hFFFFFFFD, 32'd7, bc, dc);
        chk("mult_neg_hi", 64'(hi), 64'hFFFFFFFF);
        chk("mult_neg_lo", 64'(lo), 64'hFFFFFFEB);

        run(MDU_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, bc, dc);
        chk("mult_negneg_hi", 64'(hi), 64'h0);
        chk("mult_negneg_lo", 64'(lo), 64'd15);

        run(MDU_DIV, 32'hFFFFFFF9, 32'd2, bc, dc);
        chk("div_neg_lo", 64'(lo), 64'hFFFFFFFD);
        chk("div_neg_hi", 64'(hi), 64'hFFFFFFFF);

        run(MDU_DIVU, 32'd7, 32'd2, bc, dc);
        chk("divu_lo", 64'(lo), 64'd3);
        chk("divu_hi", 64'(hi), 64'd1);
        chk("divu_busy_cycles", 64'(bc), 64'd33);

        run(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, bc, dc);
        chk("div_ovf_lo", 64'(lo), 64'h80000000);
        chk("div_ovf_hi", 64'(hi), 64'h0);

        run(MDU_DIVU, 32'd5, 32'd0, bc, dc);
        chk("divu_zero_lo", 64'(lo), 64'hFFFFFFFF);
        chk("divu_zero_hi", 64'(hi), 64'd5);
        chk("divu_zero_busy", 64'(bc), 64'd33);

        run(MDU_DIV, 32'hFFFFFFF9, 32'd0, bc, dc);
        chk("div_zero_lo", 64'(lo), 64'hFFFFFFFF);
        chk("div_zero_hi", 64'(hi), 64'hFFFFFFF9);

        // Flush on the 10th busy cycle must leave HI/LO untouched.
        run(MDU_MTHI, 32'h0000AAAA, 32'd0, bc, dc);
        run(MDU_MTLO, 32'h00005555, 32'd0, bc, dc);
        @(negedge clk);
        start = 1'b1; op = MDU_MULTU; lvalue = 32'd3; rvalue = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'h0);
        chk("flush_done", 64'(done), 64'h0);
        chk("flush_hi", 64'(hi), 64'h0000AAAA);
        chk("flush_lo", 64'(lo), 64'h00005555);

        start = 1'b1; op = MDU_MULTU; lvalue = 32'd3; rvalue = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", 64'(busy), 64'h1);
        op = MDU_DIVU; lvalue = 32'd100; rvalue = 32'd7;
        bc = 0;
        dc = 0;
        for (int i = 0; i < 60 && dc == 0; i++) begin
            if (busy) bc++;
            if (done) dc++;
            start = (bc == 5);
            if (dc == 0) @(negedge clk);
        end
        start = 1'b0;
        chk("ignore_busy_cycles", 64'(bc), 64'd33);
        chk("ignore_hi", 64'(hi), 64'h0);
        chk("ignore_lo", 64'(lo), 64'd9);
        @(negedge clk);
        chk("ignore_idle_after", 64'(busy), 64'h0);

        @(negedge clk);
        start = 1'b1; op = MDU_NOP; lvalue = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        chk("nop_done", 64'(done), 64'h0);
        chk("nop_busy", 64'(busy), 64'h0);
        chk("nop_lo", 64'(lo), 64'd9);

        // Asynchronous reset in the middle of a divide.
        run(MDU_MTHI, 32'h0000BEEF, 32'd0, bc, dc);
        @(negedge clk);
        start = 1'b1; op = MDU_DIVU; lvalue = 32'd100; rvalue = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hi", 64'(hi), 64'h0);
        chk("arst_lo", 64'(lo), 64'h0);
        chk("arst_busy", 64'(busy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run(MDU_MTHI, 32'h00001234, 32'd0, bc, dc);
        chk("mthi_hi", 64'(hi), 64'h00001234);
        chk("mthi_lo", 64'(lo), 64'h0);
        chk("mthi_done", 64'(dc), 64'd1);
        chk("mthi_busy", 64'(bc), 64'd0);
        @(negedge clk);
        chk("mthi_done_single", 64'(done), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Parametrised, multi-cycle multiply/divide unit in the execute stage, beside the combinational ALU. It performs MIPS MULT/MULTU/DIV/DIVU with a radix-2 iterative datapath and owns the architectural HI/LO registers, including MTHI/MTLO writes. While an operation is in flight it raises `busy`, and the hazard unit stalls any MFHI/MFLO or new multiply/divide until `busy` falls.

## Interface
Parameters:
- `WIDTH`, default 32: operand and HI/LO width; must be at least 4.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request valid; sampled only in IDLE.
- `op`  in  3  operation code, `MDU_*` from `mdu_pkg`.
- `lvalue`  in  WIDTH  rs operand: dividend, multiplicand, or MTHI/MTLO source.
- `rvalue`  in  WIDTH  rt operand: divisor or multiplier.
- `flush`  in  1  pipeline squash; aborts any in-flight operation.
- `busy`  out  1  high while MUL/DIV/FIX is active.
- `done`  out  1  one-cycle pulse when HI/LO is updated.
- `hi`  out  WIDTH  architectural HI register.
- `lo`  out  WIDTH  architectural LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- **Accept (IDLE, `start`=1, `flush`=0)**
  - MULT/DIV: latch the absolute values of both operands and record the result signs.
  - MULTU/DIVU: latch the operands unchanged; no sign correction.
  - Load the iteration counter with WIDTH−1 and go to MUL or DIV.
  - MTHI/MTLO: write `lvalue` to `hi`/`lo` at the accept edge, pulse `done`, and stay in IDLE. `busy` is never raised.
  - NOP (000) and the undefined code 111: no effect and no `done`.
- **MUL**: shift-add, one partial product per cycle into a 2·WIDTH accumulator.
- **DIV**: restoring division, one quotient bit per cycle; the remainder register is WIDTH+1 bits.
- Counter reaches 0: go to FIX.
- **FIX**
  - Multiply: negate the 2·WIDTH product if the operand signs differ.
  - Divide: quotient negated if signs differ; remainder takes the sign of the dividend.
  - Write `hi` (upper half / remainder) and `lo` (lower half / quotient), pulse `done`, return to IDLE.
- **Divide by zero**: no trap. Result is `lo` = all ones, `hi` = `lvalue` unmodified, with normal latency and no sign correction.
- **Signed overflow** (most-negative / −1): `lo` = most-negative value (wraps), `hi` = 0.
- **`start` while `busy`**: ignored. The request is not queued and there is no error output.
- **`flush`**
  - Any non-IDLE state goes to IDLE at the next edge; `hi`/`lo` unchanged; no `done`.
  - `flush` with `start` in IDLE: the request is dropped.
  - `flush` during FIX wins: HI/LO are not written.
- **Reset** (`rst_n` low, at any time including mid-operation): immediately `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.

## Timing
- Let E0 be the accept edge for MULT/MULTU/DIV/DIVU.
- Iteration edges are E1..E(WIDTH); FIX edge is E(WIDTH+1).
- `busy` is high from after E0 through before E(WIDTH+1): WIDTH+1 cycles.
- New `hi`/`lo` and `done`=1 are visible in the cycle after E(WIDTH+1). `busy` is already 0 there, so a new `start` is accepted at the next edge.
- Throughput: one multiply/divide per WIDTH+2 cycles, back-to-back.
- MTHI/MTLO: 1 cycle. Register updated at E0, `done` high in the following cycle.
- `hi`, `lo`, `busy`, `done` are all registered; there is no combinational input-to-output path.

## Structure
- `mdu_pkg` holds:
  - op localparams: `MDU_NOP`=000, `MDU_MULT`=001, `MDU_MULTU`=010, `MDU_DIV`=011, `MDU_DIVU`=100, `MDU_MTHI`=101, `MDU_MTLO`=110;
  - the state encoding (IDLE, MUL, DIV, FIX);
  - the `mdu_op_t` typedef.
- Sub-module `mdu_sign_adjust`: combinational, parametrised conditional-negate. It is instantiated for the operand absolute value at accept and for the result correction in FIX.
- The control FSM, counter and shared accumulator live in `mdu` itself.

## Test plan
Values below are for WIDTH=32.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001; `busy` high exactly 33 cycles; `done` single pulse.
- MULT 0xFFFFFFFD (−3) × 7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- Divides, normal:
  - DIV 0xFFFFFFF9 (−7) / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIVU 7 / 2 -> `lo`=3, `hi`=1.
- Divides, boundary:
  - DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
  - DIVU 5 / 0 -> `lo`=0xFFFFFFFF, `hi`=5.
- Abort and ignore:
  - Preload HI/LO = 0xAAAA/0x5555; MULTU 3×3; `flush` at the 10th `busy` cycle -> HI/LO stay 0xAAAA/0x5555, no `done`, `busy`=0 next cycle.
  - A `start` in that next cycle is accepted.
  - A `start` asserted mid-operation is ignored.
- Reset and moves:
  - `rst_n` low mid-DIV -> `hi`=`lo`=0 and `busy`=0 without waiting for a clock edge.
  - After reset release, MTHI 0x1234 -> `hi`=0x1234 one edge later, `done` pulsed, `busy` never high.
